// File: rtl/hilo_div_stall_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencing controller: the stall vector
// patterns, the divider FSM state encoding and the default datapath width.
package cpu_defs_pkg;

    localparam int DIV_DATA_W = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_BUSY    = 2'd2,
        S_DONE    = 2'd3
    } div_state_t;

endpackage

// File: rtl/hilo_div_stall_ctrl_if.sv
// Pipeline-side bundle of the HI/LO controller: stall requests, flush and the
// divide handshake. master = pipeline, slave = controller.
interface hilo_div_stall_ctrl_if #(parameter int DATA_W = 32);
    logic              stallreq_if_i;
    logic              stallreq_id_i;
    logic              stallreq_ex_i;
    logic              stallreq_mem_i;
    logic              flush_i;
    logic              div_start_i;
    logic              div_signed_i;
    logic [DATA_W-1:0] div_opa_i;
    logic [DATA_W-1:0] div_opb_i;
    logic [DATA_W-1:0] div_result_hi_o;
    logic [DATA_W-1:0] div_result_lo_o;
    logic              div_ready_o;
    logic [5:0]        stall_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
               flush_i, div_start_i, div_signed_i, div_opa_i, div_opb_i,
        input  div_result_hi_o, div_result_lo_o, div_ready_o, stall_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
               flush_i, div_start_i, div_signed_i, div_opa_i, div_opb_i,
        output div_result_hi_o, div_result_lo_o, div_ready_o, stall_o
    );
endinterface

// File: rtl/hilo_div_stall_ctrl_div_core.sv
// Iterative restoring divider datapath: one quotient bit per step.
// HILO_DIV_SIGNED_EN adds magnitude conversion and sign fix-up for DIV.
module hilo_div_stall_ctrl_div_core #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              sgn,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic              last,
    output logic [DATA_W-1:0] fin_quo,
    output logic [DATA_W-1:0] fin_rem
);
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              borrow;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;

    // quo starts as the dividend and fills with quotient bits from the right
    // while dividend bits leave from the left into the partial remainder.
    assign shifted = {rem, quo[DATA_W-1]};
    assign borrow  = shifted < {1'b0, dvs};
    assign diff    = shifted[DATA_W-1:0] - dvs;
    assign rem_nxt = borrow ? shifted[DATA_W-1:0] : diff;
    assign quo_nxt = {quo[DATA_W-2:0], ~borrow};
    assign last    = (cnt == CNT_W'(DATA_W - 1));

`ifdef HILO_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign mag_a   = (sgn && opa[DATA_W-1]) ? -opa : opa;
    assign mag_b   = (sgn && opb[DATA_W-1]) ? -opb : opb;
    assign fin_quo = neg_q ? -quo_nxt : quo_nxt;
    assign fin_rem = neg_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            neg_q <= sgn && (opa[DATA_W-1] ^ opb[DATA_W-1]);
            neg_r <= sgn && opa[DATA_W-1];
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign mag_a      = opa;
    assign mag_b      = opb;
    assign fin_quo    = quo_nxt;
    assign fin_rem    = rem_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= mag_a;
            dvs <= mag_b;
            cnt <= '0;
        end else if (step) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hilo_div_stall_ctrl.sv
// HI/LO sequencing controller: stall arbitration plus the divider FSM.
// Define HILO_DIV_SIGNED_EN to honour div_signed_i (signed DIV).
module hilo_div_stall_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    hilo_div_stall_ctrl_if.slave  bus
);
    div_state_t        state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              ready_q;
    logic              div_stall;
    logic              core_load;
    logic              core_step;
    logic              core_last;
    logic [DATA_W-1:0] fin_quo;
    logic [DATA_W-1:0] fin_rem;
    logic [5:0]        stall;

    // EX is released in DONE so it advances on the same edge the FSM leaves.
    assign div_stall = bus.div_start_i && (state != S_DONE);
    assign core_load = (state == S_IDLE) && bus.div_start_i && !bus.flush_i
                       && (bus.div_opb_i != '0);
    assign core_step = (state == S_BUSY) && bus.div_start_i && !bus.flush_i;

    always_comb begin
        stall = STALL_NONE;
        if (bus.flush_i)                           stall = STALL_NONE;
        else if (bus.stallreq_mem_i)               stall = STALL_MEM;
        else if (bus.stallreq_ex_i || div_stall)   stall = STALL_EX;
        else if (bus.stallreq_id_i)                stall = STALL_ID;
        else if (bus.stallreq_if_i)                stall = STALL_IF;
    end

    hilo_div_stall_ctrl_div_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_div_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .sgn     (bus.div_signed_i),
        .opa     (bus.div_opa_i),
        .opb     (bus.div_opb_i),
        .last    (core_last),
        .fin_quo (fin_quo),
        .fin_rem (fin_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.flush_i) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.div_start_i)
                            state <= (bus.div_opb_i == '0) ? S_DIVZERO : S_BUSY;
                    end
                    S_DIVZERO: begin
                        state   <= S_DONE;
                        hi_q    <= '0;
                        lo_q    <= '0;
                        ready_q <= 1'b1;
                    end
                    S_BUSY: begin
                        if (!bus.div_start_i) begin
                            state <= S_IDLE;
                        end else if (core_last) begin
                            state   <= S_DONE;
                            hi_q    <= fin_rem;
                            lo_q    <= fin_quo;
                            ready_q <= 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.stall_o         = stall;
    assign bus.div_result_hi_o = hi_q;
    assign bus.div_result_lo_o = lo_q;
    assign bus.div_ready_o     = ready_q;
endmodule

// File: tb/tb_hilo_div_stall_ctrl.sv
// Self-checking bench for hilo_div_stall_ctrl: stall priority table, hand
// sequences for divide corner cases and random divides against a model.
module tb_hilo_div_stall_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

`ifdef HILO_DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    hilo_div_stall_ctrl_if #(.DATA_W(32)) bus ();

    hilo_div_stall_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       fl;
        logic       mem;
        logic       ex;
        logic       id;
        logic       ifs;
        logic [5:0] exp;
    } stall_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference divider from the arithmetic definition, not the iteration.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (s && SIGNED_BUILD) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input string nm);
        logic [31:0] eq;
        logic [31:0] er;
        logic [5:0]  rdy_stall;
        int          cyc;
        int          stl;
        bit          got;
        model(a, b, s, eq, er);
        @(negedge clk);
        bus.div_opa_i    = a;
        bus.div_opb_i    = b;
        bus.div_signed_i = s;
        bus.div_start_i  = 1'b1;
        #1;
        stl = (bus.stall_o == 6'b001111) ? 1 : 0;
        cyc = 0;
        got = 1'b0;
        rdy_stall = 6'h3f;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                bus.div_opa_i = $urandom;
                bus.div_opb_i = $urandom;
            end
            if (bus.div_ready_o) begin
                got = 1'b1;
                rdy_stall = bus.stall_o;
            end else if (bus.stall_o == 6'b001111) begin
                stl++;
            end
        end
        chk({nm, " ready seen"}, 64'(got), 64'd1);
        chk({nm, " latency"}, 64'(cyc), (b == 0) ? 64'd2 : 64'd33);
        chk({nm, " stall cycles"}, 64'(stl), (b == 0) ? 64'd2 : 64'd33);
        chk({nm, " stall in ready cycle"}, 64'(rdy_stall), 64'd0);
        chk({nm, " lo"}, 64'(bus.div_result_lo_o), 64'(eq));
        chk({nm, " hi"}, 64'(bus.div_result_hi_o), 64'(er));
        @(negedge clk);
        bus.div_start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " ready one pulse"}, 64'(bus.div_ready_o), 64'd0);
        chk({nm, " lo held"}, 64'(bus.div_result_lo_o), 64'(eq));
    endtask

    // Start a divide, disturb it after `cyc` edges, and confirm no ready pulse.
    task automatic abort_div(input int cyc, input int kind, input string nm);
        int pulses;
        @(negedge clk);
        bus.div_opa_i    = 32'd1000;
        bus.div_opb_i    = 32'd3;
        bus.div_signed_i = 1'b0;
        bus.div_start_i  = 1'b1;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        if (kind == 0) begin
            bus.flush_i = 1'b1;
            #1;
            chk({nm, " flush stall"}, 64'(bus.stall_o), 64'd0);
        end else if (kind == 1) begin
            bus.div_start_i = 1'b0;
        end else begin
            rst = 1'b1;
        end
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.div_start_i = 1'b0;
        rst             = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.div_ready_o) pulses++;
        end
        chk({nm, " no ready pulse"}, 64'(pulses), 64'd0);
    endtask

    stall_vec_t tbl[8];

    initial begin
        logic [31:0] lo_before;
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{"none",      0, 0, 0, 0, 0, 6'b000000};
        tbl[1] = '{"if",        0, 0, 0, 0, 1, 6'b000011};
        tbl[2] = '{"id+if",     0, 0, 0, 1, 1, 6'b000111};
        tbl[3] = '{"ex+id",     0, 0, 1, 1, 0, 6'b001111};
        tbl[4] = '{"mem+id+if", 0, 1, 0, 1, 1, 6'b011111};
        tbl[5] = '{"mem+ex",    0, 1, 1, 0, 0, 6'b011111};
        tbl[6] = '{"flush all", 1, 1, 1, 1, 1, 6'b000000};
        tbl[7] = '{"flush if",  1, 0, 0, 0, 1, 6'b000000};

        // Reset with every request high.
        rst = 1'b1;
        bus.stallreq_if_i  = 1'b1;
        bus.stallreq_id_i  = 1'b1;
        bus.stallreq_ex_i  = 1'b1;
        bus.stallreq_mem_i = 1'b1;
        bus.flush_i        = 1'b0;
        bus.div_start_i    = 1'b1;
        bus.div_signed_i   = 1'b0;
        bus.div_opa_i      = 32'd5;
        bus.div_opb_i      = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.div_start_i = 1'b0;
        #1;
        chk("reset stall mem wins", 64'(bus.stall_o), 64'h1f);
        chk("reset hi", 64'(bus.div_result_hi_o), 64'd0);
        chk("reset lo", 64'(bus.div_result_lo_o), 64'd0);
        chk("reset ready", 64'(bus.div_ready_o), 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.flush_i        = tbl[i].fl;
            bus.stallreq_mem_i = tbl[i].mem;
            bus.stallreq_ex_i  = tbl[i].ex;
            bus.stallreq_id_i  = tbl[i].id;
            bus.stallreq_if_i  = tbl[i].ifs;
            #1;
            chk({"stall ", tbl[i].name}, 64'(bus.stall_o), 64'(tbl[i].exp));
        end
        @(negedge clk);
        bus.flush_i        = 1'b0;
        bus.stallreq_mem_i = 1'b0;
        bus.stallreq_ex_i  = 1'b0;
        bus.stallreq_id_i  = 1'b0;
        bus.stallreq_if_i  = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, "divu 100/7");
        chk("divu 100/7 lo const", 64'(bus.div_result_lo_o), 64'd14);
        chk("divu 100/7 hi const", 64'(bus.div_result_hi_o), 64'd2);
        do_div(32'hDEADBEEF, 32'd0, 1'b0, "div by zero");

        do_div(32'd55, 32'd5, 1'b0, "divu 55/5");
        lo_before = bus.div_result_lo_o;
        abort_div(10, 0, "flush busy");
        chk("flush results unchanged", 64'(bus.div_result_lo_o), 64'(lo_before));
        do_div(32'hFFFFFFFF, 32'h10, 1'b0, "restart ffffffff/10");
        chk("restart lo const", 64'(bus.div_result_lo_o), 64'h0FFFFFFF);
        chk("restart hi const", 64'(bus.div_result_hi_o), 64'hF);

        abort_div(7, 1, "cancel busy");
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, "div -7/2");
        chk("div -7/2 lo const", 64'(bus.div_result_lo_o),
            SIGNED_BUILD ? 64'hFFFFFFFD : 64'h7FFFFFFC);
        chk("div -7/2 hi const", 64'(bus.div_result_hi_o),
            SIGNED_BUILD ? 64'hFFFFFFFF : 64'd1);
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div min/-1");
        do_div(32'd12345, 32'd1, 1'b0, "divu by one");

        abort_div(5, 2, "reset busy");
        chk("reset busy hi", 64'(bus.div_result_hi_o), 64'd0);
        chk("reset busy lo", 64'(bus.div_result_lo_o), 64'd0);

        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            do_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hilo_div_stall_ctrl.md
Name: hilo_div_stall_ctrl

Overview:
- Pipeline sequencing controller for the HI/LO path.
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- Owns a multi-cycle 32-bit divider FSM. Stalls EX while a DIV/DIVU is in flight, then hands the quotient/remainder to EX for HI/LO writeback.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_if_i  in  1  IF stage stall request.
- stallreq_id_i  in  1  ID stage stall request (load-use hazard).
- stallreq_ex_i  in  1  EX stage stall request (non-divide).
- stallreq_mem_i  in  1  MEM stage stall request.
- flush_i  in  1  pipeline flush (exception); aborts the divide.
- div_start_i  in  1  EX requests a divide; held high until div_ready_o.
- div_signed_i  in  1  1 = DIV, 0 = DIVU. Honoured only with the optional feature.
- div_opa_i  in  DATA_W  dividend.
- div_opb_i  in  DATA_W  divisor.
- div_result_hi_o  out  DATA_W  remainder (HI).
- div_result_lo_o  out  DATA_W  quotient (LO).
- div_ready_o  out  1  result valid, one-cycle pulse.
- stall_o  out  6  stall vector to pipeline registers.

Behaviour:
- Reset: FSM to IDLE; counter 0; div_result_hi_o/lo_o 0; div_ready_o 0; stall_o 6'b000000 (no requests asserted). Reset mid-divide abandons it with no ready pulse.
- stall_o is combinational, with this priority:
  - flush_i → 6'b000000.
  - else stallreq_mem_i → 6'b011111.
  - else stallreq_ex_i or div_stall → 6'b001111.
  - else stallreq_id_i → 6'b000111.
  - else stallreq_if_i → 6'b000011.
  - else 6'b000000.
  - Each pattern freezes stages up to the requester; the next register inserts a bubble.
- div_stall = div_start_i && state != DONE.
- FSM states: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - div_start_i && !flush_i && opb==0 → DIVZERO.
  - div_start_i && !flush_i && opb!=0 → BUSY. Latch operands; counter=0; partial remainder=0.
- DIVZERO: next cycle → DONE with hi=0, lo=0.
- BUSY: one restoring shift-subtract step per cycle.
  - Counter increments each step.
  - After DATA_W steps (counter==DATA_W-1 at the edge) → DONE.
  - Latency from the start edge to div_ready_o: 33 cycles nonzero, 2 cycles zero divisor.
- DONE:
  - div_ready_o=1 for exactly this cycle; results held stable until the next start.
  - Unconditional → IDLE.
  - div_start_i in DONE is never treated as a new request; EX advances at this edge.
- Any state with flush_i=1 → IDLE next edge, no ready pulse, results unchanged.
- div_start_i falling while BUSY (EX cancelled) → IDLE next edge.
- Arithmetic: unsigned restoring division on DATA_W+1-bit partial remainder. Quotient bit = no-borrow.
- Operands sampled only at the IDLE→BUSY edge; later input changes are ignored.

Optional Feature:
- Macro HILO_DIV_SIGNED_EN.
- Defined:
  - div_signed_i=1 converts negative operands to magnitude before iteration.
  - Quotient negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
- Undefined: div_signed_i ignored; all divides unsigned; the conversion logic is absent.

Decomposition:
- Shared package (cpu_defs_pkg):
  - STALL_NONE/IF/ID/EX/MEM vector constants.
  - FSM state enum (2-bit).
  - DATA_W.
- One natural sub-module: div_core. Holds the iterative datapath: partial remainder, quotient shift register, counter, and the sign fix-up under the macro. The top keeps the FSM and stall arbitration.

Test Plan:
- Reset held 2 cycles with all requests high → stall_o=6'b000000 while flush low? No: after reset deassert, stall_o=6'b011111 (mem wins). Results 0, ready 0.
- Priority: stallreq_id_i=1, stallreq_if_i=1 → 6'b000111. Add stallreq_mem_i → 6'b011111. Add flush_i → 6'b000000.
- DIVU: opa=100, opb=7, start held → stall_o=6'b001111 for 33 cycles. Ready pulse: lo=14, hi=2. Stall drops in the ready cycle.
- Divide by zero: opa=0xDEADBEEF, opb=0 → ready on cycle 2, hi=lo=0.
- Flush at BUSY cycle 10 → state IDLE, no ready pulse. Restart 0xFFFFFFFF/0x10 → lo=0x0FFFFFFF, hi=0xF.
- With HILO_DIV_SIGNED_EN: DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro the same inputs give the unsigned result lo=0x7FFFFFFC, hi=1.
